// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: pads a byte-counted word stream, loads 16-word
// blocks into a Sha256 core and streams the 8-word digest back out.
module sha256_msg_sequencer #(
  parameter int LEN_W   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic        busy,
  output logic        err_timeout,
  output logic        core_rst_n,
  output logic        core_calcu_en,
  output logic [31:0] core_word,
  input  logic        core_calcu_rdy,
  output logic        core_read_en,
  input  logic [31:0] core_word_out
);
  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_FILL, S_LOAD, S_WAIT,
    S_PAD, S_READ, S_OUT, S_ABRT
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        buf_q [16];
  logic [31:0]        buf_d [16];
  logic [31:0]        dig_buf_q [8];
  logic [31:0]        dig_buf_d [8];
  logic [4:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               padded_q, padded_d;
  logic               len_done_q, len_done_d;
  logic               pend_q, pend_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         k_q, k_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               dig_valid_q, dig_valid_d;
  logic [31:0]        dig_data_q, dig_data_d;
  logic               dig_last_q, dig_last_d;
  logic               busy_q, busy_d;
  logic               crst_n_q, crst_n_d;
  logic               cen_q, cen_d;
  logic [31:0]        cword_q, cword_d;
  logic               rden_q, rden_d;
  logic [31:0]        word;
  logic [4:0]         mark;
  logic [63:0]        len64;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    dig_buf_d  = dig_buf_q;
    idx_d      = idx_q;
    len_d      = len_q;
    padded_d   = padded_q;
    len_done_d = len_done_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    err_d      = err_q;
    word       = '0;
    mark       = '0;
    len64      = '0;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        state_d    = S_CRST;
        cnt_d      = '0;
        err_d      = 1'b0;
        idx_d      = '0;
        len_d      = '0;
        padded_d   = 1'b0;
        len_done_d = 1'b0;
        pend_d     = 1'b0;
      end
      S_CRST, S_ABRT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd1) begin
          cnt_d   = '0;
          state_d = (state_q == S_CRST) ? S_FILL : S_IDLE;
        end
      end
      S_FILL: if (in_valid) begin
        idx_d = idx_q + 5'd1;
        len_d = len_q + LEN_W'(32);
        mark  = idx_q + 5'd1;
        word  = in_data;
        if (in_last && in_bytes != 2'd0) begin
          len_d = len_q + LEN_W'({in_bytes, 3'b000});
          mark  = idx_q;
          unique case (in_bytes)
            2'd1:    word = {in_data[31:24], 24'h800000};
            2'd2:    word = {in_data[31:16], 16'h8000};
            default: word = {in_data[31:8], 8'h80};
          endcase
        end
        buf_d[idx_q[3:0]] = word;
        if (in_last) begin
          padded_d = 1'b1;
          for (int i = 0; i < 16; i++)
            if (5'(i) > idx_q) buf_d[i] = '0;
          // a full final word in slot 15 pushes the marker into the next block
          if (in_bytes == 2'd0) begin
            if (idx_q == 5'd15) pend_d = 1'b1;
            else buf_d[idx_q[3:0] + 4'd1] = 32'h8000_0000;
          end
          len64      = 64'(len_d);
          len_done_d = (mark <= 5'd13);
          if (mark <= 5'd13) begin
            buf_d[14] = len64[63:32];
            buf_d[15] = len64[31:0];
          end
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (idx_q == 5'd15) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd15) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q != 16'd0 && core_calcu_rdy) begin
          cnt_d = '0;
          if (!padded_q) begin
            state_d = S_FILL;
            idx_d   = '0;
          end else if (!len_done_q) begin
            state_d = S_PAD;
          end else begin
            state_d = S_READ;
          end
        end else if (cnt_q == 16'(TIMEOUT)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_ABRT;
        end
      end
      S_PAD: begin
        for (int i = 0; i < 16; i++) buf_d[i] = '0;
        if (pend_q) buf_d[0] = 32'h8000_0000;
        len64      = 64'(len_q);
        buf_d[14]  = len64[63:32];
        buf_d[15]  = len64[31:0];
        len_done_d = 1'b1;
        pend_d     = 1'b0;
        cnt_d      = '0;
        state_d    = S_LOAD;
      end
      S_READ: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q != 16'd0)
          dig_buf_d[cnt_q[2:0] - 3'd1] = core_word_out;
        if (cnt_q == 16'd8) begin
          cnt_d   = '0;
          k_d     = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: if (dig_ready) begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_FILL);
    busy_d      = (state_d != S_IDLE);
    crst_n_d    = !(state_d == S_CRST || state_d == S_ABRT);
    cen_d       = (state_d == S_LOAD);
    cword_d     = cen_d ? buf_d[cnt_d[3:0]] : '0;
    rden_d      = (state_d == S_READ) && (cnt_d < 16'd8);
    dig_valid_d = (state_d == S_OUT);
    dig_data_d  = dig_valid_d ? dig_buf_d[k_d] : '0;
    dig_last_d  = dig_valid_d && (k_d == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '{default: '0};
      dig_buf_q   <= '{default: '0};
      idx_q       <= '0;
      len_q       <= '0;
      padded_q    <= 1'b0;
      len_done_q  <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_data_q  <= '0;
      dig_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      crst_n_q    <= 1'b0;
      cen_q       <= 1'b0;
      cword_q     <= '0;
      rden_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      dig_buf_q   <= dig_buf_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      padded_q    <= padded_d;
      len_done_q  <= len_done_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      dig_valid_q <= dig_valid_d;
      dig_data_q  <= dig_data_d;
      dig_last_q  <= dig_last_d;
      busy_q      <= busy_d;
      crst_n_q    <= crst_n_d;
      cen_q       <= cen_d;
      cword_q     <= cword_d;
      rden_q      <= rden_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign dig_valid     = dig_valid_q;
  assign dig_data      = dig_data_q;
  assign dig_last      = dig_last_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;
  assign core_rst_n    = crst_n_q;
  assign core_calcu_en = cen_q;
  assign core_word     = cword_q;
  assign core_read_en  = rden_q;
endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// tb_sha256_msg_sequencer: directed messages through the sequencer with a
// behavioural Sha256 core and a digest scoreboard.
module tb_sha256_msg_sequencer;
  localparam int TIMEOUT = 255;
  typedef logic [31:0] wq_t [$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [1:0]  in_bytes;
  logic        dig_valid, dig_ready, dig_last;
  logic [31:0] dig_data;
  logic        busy, err_timeout;
  logic        core_rst_n, core_calcu_en, core_calcu_rdy, core_read_en;
  logic [31:0] core_word, core_word_out;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q [$];
  bit  tog   = 1'b0;
  bit  stuck = 1'b0;
  int  crst_seen = 0;

  always #5 clk = ~clk;

  sha256_msg_sequencer #(.LEN_W(64), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .dig_valid(dig_valid), .dig_ready(dig_ready),
    .dig_data(dig_data), .dig_last(dig_last),
    .busy(busy), .err_timeout(err_timeout),
    .core_rst_n(core_rst_n), .core_calcu_en(core_calcu_en),
    .core_word(core_word), .core_calcu_rdy(core_calcu_rdy),
    .core_read_en(core_read_en), .core_word_out(core_word_out)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_56 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h,
                                            input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c,
            h[159:128] + d, h[127:96] + e, h[95:64] + f,
            h[63:32] + g, h[31:0] + hh};
  endfunction

  // reference digest for a message made of whole words only
  function automatic logic [255:0] ref_full(input wq_t m);
    wq_t          p;
    logic [63:0]  bits;
    logic [255:0] h;
    logic [511:0] blk;
    p = m;
    bits = 64'(m.size()) * 64'd32;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(bits[63:32]);
    p.push_back(bits[31:0]);
    h = IV;
    for (int bk = 0; bk < p.size() / 16; bk++) begin
      for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = p[16*bk+i];
      h = compress(h, blk);
    end
    return h;
  endfunction

  // behavioural Sha256 core
  logic [255:0] core_h;
  logic [511:0] core_blk;
  int           core_wc, core_bz, core_blocks = 0;
  logic [2:0]   rptr;
  logic [31:0]  core_last_word = '0;

  always @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      core_h         <= IV;
      core_blk       <= '0;
      core_wc        <= 0;
      core_bz        <= 0;
      core_calcu_rdy <= 1'b1;
      rptr           <= '0;
      core_word_out  <= '0;
    end else begin
      if (core_calcu_en) begin
        core_blk <= {core_blk[479:0], core_word};
        if (core_wc == 15) begin
          core_h         <= compress(core_h, {core_blk[479:0], core_word});
          core_wc        <= 0;
          core_calcu_rdy <= 1'b0;
          core_bz        <= 20;
          core_blocks    <= core_blocks + 1;
          core_last_word <= core_word;
        end else begin
          core_wc <= core_wc + 1;
        end
      end else if (core_bz > 0) begin
        core_bz <= core_bz - 1;
        if (core_bz == 1 && !stuck) core_calcu_rdy <= 1'b1;
      end
      if (core_read_en) begin
        core_word_out <= core_h[255-32*rptr -: 32];
        rptr          <= rptr + 3'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic push_dig(input logic [255:0] d);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7), d[255-32*i -: 32]});
  endtask

  task automatic send(input wq_t m, input logic [1:0] lb, input int gap);
    int g;
    int n;
    bit acc;
    for (int i = 0; i < m.size(); i++) begin
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = (i == m.size() - 1);
      in_bytes = in_last ? lb : 2'd0;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 3000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) chk("in_handshake_timeout", 64'(i), 64'hffff);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 2'd0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) chk("wait_idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // digest scoreboard
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (rst_n && dig_valid && dig_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dig_unexpected got=%h", dig_data);
      end else begin
        e = exp_q.pop_front();
        if ({dig_last, dig_data} !== e) begin
          bad++;
          $display("FAIL dig_word got last=%0b data=%h want last=%0b data=%h",
                   dig_last, dig_data, e[32], e[31:0]);
        end
      end
    end
  end

  // every core reset pulse after power-up must last two cycles
  initial begin
    int  run;
    bit  ok;
    run = 0;
    ok  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        ok  = 1'b0;
      end else if (!core_rst_n) begin
        run++;
      end else begin
        if (run != 0 && ok) begin
          crst_seen++;
          total++;
          if (run != 2) begin
            bad++;
            $display("FAIL crst_width got=%0d want=2", run);
          end
        end
        run = 0;
        ok  = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    dig_ready = tog ? ~dig_ready : 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t abc, m56, m20;
    int  b0, c0, cw, erc, cyc, low;
    bit  prev_en;
    abc = '{32'h61626300};
    m56 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071};
    for (int i = 0; i < 20; i++)
      m20.push_back(32'(i) * 32'h01010101 + 32'h10203040);
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; in_bytes = 2'd0; dig_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_core_rst_n", 64'(core_rst_n), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_dig_valid", 64'(dig_valid), 64'd0);

    // "abc"
    b0 = core_blocks;
    push_dig(D_ABC);
    send(abc, 2'd3, 0);
    wait_idle();
    chk("abc_blocks", 64'(core_blocks - b0), 64'd1);
    chk("abc_lenword", 64'(core_last_word), 64'h18);

    // 56-byte message needs a separate length block
    b0 = core_blocks;
    push_dig(D_56);
    send(m56, 2'd0, 0);
    wait_idle();
    chk("m56_blocks", 64'(core_blocks - b0), 64'd2);
    chk("m56_lenword", 64'(core_last_word), 64'h1c0);

    // back-to-back with a throttled consumer
    c0  = crst_seen;
    tog = 1'b1;
    push_dig(D_ABC);
    send(abc, 2'd3, 0);
    push_dig(D_ABC);
    send(abc, 2'd3, 0);
    wait_idle();
    tog = 1'b0;
    chk("b2b_crst_pulses", 64'(crst_seen - c0), 64'd2);

    // core never signals ready
    stuck = 1'b1;
    send(abc, 2'd3, 0);
    cw = -1; erc = -1; cyc = 0; prev_en = 1'b0;
    while (erc < 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_en && !core_calcu_en && cw < 0) cw = cyc;
      prev_en = core_calcu_en;
      if (err_timeout) erc = cyc;
    end
    chk("to_latency", 64'(erc - cw), 64'(TIMEOUT + 1));
    low = 0;
    while (!core_rst_n && low < 10) begin
      low++;
      @(posedge clk); #1;
    end
    chk("to_crst_len", 64'(low), 64'd2);
    chk("to_busy_after", 64'(busy), 64'd0);
    chk("to_err_sticky", 64'(err_timeout), 64'd1);
    stuck = 1'b0;
    push_dig(D_ABC);
    send(abc, 2'd3, 0);
    chk("to_err_cleared", 64'(err_timeout), 64'd0);
    wait_idle();

    // asynchronous reset in the middle of LOAD
    send(abc, 2'd3, 0);
    repeat (7) begin @(posedge clk); #1; end
    chk("ar_in_load", 64'(core_calcu_en), 64'd1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("ar_outs_zero",
        64'({in_ready, dig_valid, dig_data, dig_last, busy, err_timeout,
             core_rst_n, core_calcu_en, core_read_en}), 64'd0);
    chk("ar_word_zero", 64'(core_word), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_core_rst_n", 64'(core_rst_n), 64'd1);
    push_dig(D_ABC);
    send(abc, 2'd3, 0);
    wait_idle();

    // 20 words with input gaps
    b0 = core_blocks;
    push_dig(ref_full(m20));
    send(m20, 2'd0, 3);
    wait_idle();
    chk("m20_blocks", 64'(core_blocks - b0), 64'd2);
    chk("m20_lenword", 64'(core_last_word), 64'h280);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
